// File: rtl/rv32_pkg.sv
// Shared RV32 types and opcode-field constants used by the immediate generator.
package rv32_pkg;

  // Extended immediate as seen by the datapath.
  typedef logic [31:0] rv32_imm_t;

  // Immediate format tag; encodings are visible on the port and must not change.
  typedef enum logic [2:0] {
    IMM_FMT_NONE  = 3'd0,
    IMM_FMT_I     = 3'd1,
    IMM_FMT_S     = 3'd2,
    IMM_FMT_B     = 3'd3,
    IMM_FMT_U     = 3'd4,
    IMM_FMT_J     = 3'd5,
    IMM_FMT_SHAMT = 3'd6
  } rv32_imm_fmt_t;

  // Opcode field rv_instr[6:2]; the two low bits are always 2'b11 for RV32I
  // and are not used to select a format.
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // funct3[1:0] value shared by SLLI (001) and SRLI/SRAI (101).
  localparam logic [1:0] F3_SHIFT_LO = 2'b01;

endpackage

// File: rtl/rv32_imm_gen.sv
// RV32I immediate generator: decodes the immediate format from the opcode,
// extracts and extends the immediate, and registers both with one cycle of
// latency. No validation of register or funct fields is performed.
module rv32_imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   rv_instr,
  output rv32_imm_t     rv_imm,
  output rv32_imm_fmt_t rv_imm_fmt
);

  logic [4:0]      opc;
  rv32_imm_fmt_t   imm_fmt_d, imm_fmt_q;
  logic [XLEN-1:0] imm_d, imm_q;

  // The two low opcode bits carry no format information.
  logic unused_opc_lo;
  assign unused_opc_lo = ^rv_instr[1:0];

  assign opc = rv_instr[6:2];

  // Decode format from the opcode and assemble the matching immediate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    imm_fmt_d = IMM_FMT_NONE;
    imm_d     = '0;

    unique case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: imm_fmt_d = IMM_FMT_I;
      OPC_STORE:                                                imm_fmt_d = IMM_FMT_S;
      OPC_BRANCH:                                               imm_fmt_d = IMM_FMT_B;
      OPC_LUI, OPC_AUIPC:                                       imm_fmt_d = IMM_FMT_U;
      OPC_JAL:                                                  imm_fmt_d = IMM_FMT_J;
      default:                                                  imm_fmt_d = IMM_FMT_NONE;
    endcase

    // Shift-immediates carry a 5-bit shamt; bit 30 only selects SRAI.
    if (opc == OPC_OP_IMM && rv_instr[13:12] == F3_SHIFT_LO) begin
      imm_fmt_d = IMM_FMT_SHAMT;
    end

    unique case (imm_fmt_d)
      IMM_FMT_I:     imm_d = {{21{rv_instr[31]}}, rv_instr[30:20]};
      IMM_FMT_S:     imm_d = {{21{rv_instr[31]}}, rv_instr[30:25], rv_instr[11:7]};
      IMM_FMT_B:     imm_d = {{20{rv_instr[31]}}, rv_instr[7], rv_instr[30:25],
                              rv_instr[11:8], 1'b0};
      IMM_FMT_U:     imm_d = {rv_instr[31:12], 12'b0};
      IMM_FMT_J:     imm_d = {{12{rv_instr[31]}}, rv_instr[19:12], rv_instr[20],
                              rv_instr[30:21], 1'b0};
      IMM_FMT_SHAMT: imm_d = {27'b0, rv_instr[24:20]};
      default:       imm_d = '0;
    endcase
  end

  // Output register; reset wins over the instruction sampled at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      imm_q     <= '0;
      imm_fmt_q <= IMM_FMT_NONE;
    end else begin
      imm_q     <= imm_d;
      imm_fmt_q <= imm_fmt_d;
    end
  end

  assign rv_imm     = imm_q;
  assign rv_imm_fmt = imm_fmt_q;

endmodule

// File: tb/tb_rv32_imm_gen.sv
// Self-checking bench for rv32_imm_gen: directed instruction vectors followed
// by randomized back-to-back traffic with occasional resets, compared against
// an arithmetic reference model of the immediate encodings.
module tb_rv32_imm_gen;
  import rv32_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   rv_instr = '0;
  rv32_imm_t     rv_imm;
  rv32_imm_fmt_t rv_imm_fmt;

  int n_checks = 0;
  int n_errors = 0;

  rv32_imm_gen #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rv_instr   (rv_instr),
    .rv_imm     (rv_imm),
    .rv_imm_fmt (rv_imm_fmt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: formats as numeric tags, immediates as signed sums of
  // weighted instruction fields.
  function automatic void ref_model(input logic [31:0] ins,
                                    output logic [31:0] imm, output int fmt);
    int op;
    int sgn;
    op  = int'(ins[6:2]);
    sgn = ins[31] ? -1 : 0;
    case (op)
      0, 4, 25, 3, 28: fmt = 1;
      8:               fmt = 2;
      24:              fmt = 3;
      13, 5:           fmt = 4;
      27:              fmt = 5;
      default:         fmt = 0;
    endcase
    if (op == 4 && int'(ins[13:12]) == 1) fmt = 6;
    case (fmt)
      1: imm = 32'($signed(ins) >>> 20);
      2: imm = 32'(sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]));
      3: imm = 32'(sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                   + int'(ins[11:8]) * 2);
      4: imm = ins & 32'hFFFF_F000;
      5: imm = 32'(sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                   + int'(ins[30:21]) * 2);
      6: imm = 32'(int'(ins[24:20]));
      default: imm = 32'h0;
    endcase
  endfunction

  // Apply one instruction (optionally under reset) and check the result one edge later.
  task automatic apply(input string tag, input logic [31:0] ins, input logic do_rst);
    logic [31:0] e_imm;
    int          e_fmt;
    rv_instr = ins;
    rst      = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      e_imm = 32'h0;
      e_fmt = 0;
    end else begin
      ref_model(ins, e_imm, e_fmt);
    end
    check({tag, "_imm"}, rv_imm, e_imm);
    check({tag, "_fmt"}, 32'(rv_imm_fmt), 32'(e_fmt));
  endtask

  // Directed sanity vectors with hand-derived expectations.
  task automatic apply_known(input string tag, input logic [31:0] ins,
                             input logic [31:0] e_imm, input int e_fmt);
    rv_instr = ins;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_imm"}, rv_imm, e_imm);
    check({tag, "_fmt"}, 32'(rv_imm_fmt), 32'(e_fmt));
  endtask

  int opcodes[11] = '{0, 3, 4, 5, 8, 12, 13, 24, 25, 27, 28};

  initial begin
    logic [31:0] ins;

    // Reset held with a valid I-type on the input.
    rst      = 1'b1;
    rv_instr = 32'hFFF0_0093;
    repeat (2) @(posedge clk);
    #1;
    check("reset_imm", rv_imm, 32'h0);
    check("reset_fmt", 32'(rv_imm_fmt), 32'd0);

    // First edge out of reset registers the instruction normally.
    apply_known("addi",   32'hFFF0_0093, 32'hFFFF_FFFF, 1);
    apply_known("sw",     32'h0020_A423, 32'h0000_0008, 2);
    apply_known("beq",    32'hFE00_0EE3, 32'hFFFF_FFFC, 3);
    apply_known("jal",    32'h0010_00EF, 32'h0000_0800, 5);
    apply_known("lui",    32'h1234_52B7, 32'h1234_5000, 4);
    apply_known("slli",   32'h0050_9093, 32'h0000_0005, 6);
    apply_known("srai",   32'h4030_D093, 32'h0000_0003, 6);
    apply_known("add",    32'h0020_81B3, 32'h0000_0000, 0);
    apply_known("auipc",  32'hFFFF_F517, 32'hFFFF_F000, 4);
    apply_known("jalr",   32'h8000_00E7, 32'hFFFF_F800, 1);

    // Mid-stream reset discards its instruction; next instruction is normal.
    apply_known("pre_rst", 32'h0020_A423, 32'h0000_0008, 2);
    apply("mid_rst",       32'h1234_52B7, 1'b1);
    apply_known("post_rst", 32'hFE00_0EE3, 32'hFFFF_FFFC, 3);

    // Randomized back-to-back traffic, mostly recognised opcodes.
    for (int i = 0; i < 600; i++) begin
      ins = $urandom();
      if ($urandom_range(3) != 0) ins[6:2] = 5'(opcodes[$urandom_range(10)]);
      ins[1:0] = 2'b11;
      apply("rand", ins, ($urandom_range(31) == 0));
    end

    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
